// File: rtl/booth_mul.sv
// Sequential signed radix-2 Booth multiplier, one Booth step per clock, start/done handshake.
// Optional MUL_SAT8_EN adds registered WIDTH-bit saturated product (sat) and overflow flag (ovf).
module booth_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     inbus1,
  input  logic [WIDTH-1:0]     inbus2,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 done
`ifdef MUL_SAT8_EN
  ,
  output logic [WIDTH-1:0]     sat,
  output logic                 ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [WIDTH:0]       a;
  logic [WIDTH-1:0]     q;
  logic                 q_1;
  logic [WIDTH:0]       m;
  logic [CW-1:0]        cnt;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       a_sh;
  logic [WIDTH-1:0]     q_sh;
  logic [2*WIDTH-1:0]   prod_nx;
  logic                 load;

  assign load = (state != STEP) && start;

  always_comb begin
    sum = a;
    unique case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    // Arithmetic shift of {A,Q,Q_1}; the guard bit keeps A-M exact for M = -2^(WIDTH-1).
    a_sh    = {sum[WIDTH], sum[WIDTH:1]};
    q_sh    = {sum[0], q[WIDTH-1:1]};
    prod_nx = {a_sh[WIDTH-1:0], q_sh};
  end

`ifdef MUL_SAT8_EN
  logic [WIDTH:0]   hi;
  logic             ovf_nx;
  logic [WIDTH-1:0] sat_nx;

  always_comb begin
    hi     = prod_nx[2*WIDTH-1:WIDTH-1];
    ovf_nx = !((hi == '0) || (hi == '1));
    sat_nx = prod_nx[WIDTH-1:0];
    if (ovf_nx)
      sat_nx = prod_nx[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat <= '0;
      ovf <= 1'b0;
    end else if (state == STEP && cnt == CW'(1)) begin
      sat <= sat_nx;
      ovf <= ovf_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prod  <= '0;
      done  <= 1'b0;
      a     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      m     <= '0;
      cnt   <= '0;
    end else if (load) begin
      a     <= '0;
      q     <= inbus1;
      q_1   <= 1'b0;
      m     <= {inbus2[WIDTH-1], inbus2};
      cnt   <= CW'(WIDTH);
      done  <= 1'b0;
      state <= STEP;
    end else if (state == STEP) begin
      a   <= a_sh;
      q   <= q_sh;
      q_1 <= q[0];
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        prod  <= prod_nx;
        done  <= 1'b1;
        state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// Directed-vector bench for booth_mul: products, latency, ignored start, mid-op reset, back-to-back.
module tb_booth_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  inbus1 = '0;
  logic [7:0]  inbus2 = '0;
  logic [15:0] prod;
  logic        done;
`ifdef MUL_SAT8_EN
  logic [7:0]  sat;
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  booth_mul #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inbus1 (inbus1),
    .inbus2 (inbus2),
    .prod   (prod),
    .done   (done)
`ifdef MUL_SAT8_EN
    ,
    .sat    (sat),
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges until done rises; returns -1 if it never does within the budget.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic mul_run(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp);
    int n;
    @(negedge clk);
    inbus1 = x;
    inbus2 = y;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, done}, 32'd0);
    wait_done(n);
    chk({tag, "_lat"}, n, 32'd8);
    chk({tag, "_prod"}, {16'd0, prod}, {16'd0, exp});
  endtask

  initial begin
    int n;
    #5;
    chk("rst_prod", {16'd0, prod}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #9 rst = 1'b1;

    mul_run("m49x3", -8'sd49, -8'sd3, 16'h0093);
`ifdef MUL_SAT8_EN
    chk("sat_147", {24'd0, sat}, 32'h7F);
    chk("ovf_147", {31'd0, ovf}, 32'd1);
`endif
    mul_run("p49xm3", 8'sd49, -8'sd3, 16'hFF6D);
    mul_run("p59x4", 8'sd59, 8'sd4, 16'h00EC);
`ifdef MUL_SAT8_EN
    chk("sat_236", {24'd0, sat}, 32'h7F);
    chk("ovf_236", {31'd0, ovf}, 32'd1);
`endif
    chk("held_done", {31'd0, done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("held_prod", {16'd0, prod}, 32'h00EC);
    mul_run("min_sq", 8'h80, 8'h80, 16'h4000);
    mul_run("minxmax", 8'h80, 8'h7F, 16'hC080);
    mul_run("zero", 8'h00, -8'sd77, 16'h0000);

    // Start pulse, then a second start with new operands at step 3 must be ignored.
    @(negedge clk);
    inbus1 = 8'sd11; inbus2 = -8'sd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    inbus1 = 8'sd100; inbus2 = 8'sd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 4;
    begin
      int m;
      wait_done(m);
      n = (m < 0) ? -1 : n + m;
    end
    chk("ign_lat", n, 32'd8);
    chk("ign_prod", {16'd0, prod}, 32'h0000FFC9);

    // Reset during step 4 clears outputs immediately.
    @(negedge clk);
    inbus1 = 8'sd5; inbus2 = 8'sd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_prod", {16'd0, prod}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mul_run("after_rst", 8'sd7, -8'sd6, 16'hFFD6);
`ifdef MUL_SAT8_EN
    chk("sat_m42", {24'd0, sat}, 32'hD6);
    chk("ovf_m42", {31'd0, ovf}, 32'd0);
`endif
    mul_run("p7x6", 8'sd7, 8'sd6, 16'd42);
    chk("p7x6_done", {31'd0, done}, 32'd1);

    // start held high: results back to back, done pulses one cycle.
    @(negedge clk);
    inbus1 = 8'sd3; inbus2 = -8'sd5; start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n);
    chk("b2b1_lat", n, 32'd8);
    chk("b2b1_prod", {16'd0, prod}, 32'h0000FFF1);
    @(negedge clk);
    inbus1 = 8'sd9; inbus2 = 8'sd9;
    @(posedge clk);
    #1;
    chk("b2b_pulse", {31'd0, done}, 32'd0);
    chk("b2b_stale", {16'd0, prod}, 32'h0000FFF1);
    wait_done(n);
    start = 1'b0;
    chk("b2b2_lat", n, 32'd8);
    chk("b2b2_prod", {16'd0, prod}, 32'd81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
